// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver
//   8N1 asynchronous serial receiver feeding the program-upload RAM loader.
//   The line is double-flop synchronised, the start bit is verified at its
//   midpoint, and every following bit is sampled one bit time later.
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous, active-low
//   rx         : asynchronous serial input, idle high
//   dataOut    : last correctly framed byte, held until the next good frame
//   newData    : one-cycle strobe, dataOut has just been updated
//   framingErr : one-cycle strobe, stop bit was sampled low
//   busy       : high whenever the receiver is not idle
module uart_byte_receiver #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] dataOut,
  output logic       newData,
  output logic       framingErr,
  output logic       busy
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          new_data_q, new_data_d;
  logic          framing_err_q, framing_err_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      tick_q        <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      data_out_q    <= '0;
      new_data_q    <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_meta_q     <= rx;
      rx_s_q        <= rx_meta_q;
      tick_q        <= tick_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      new_data_q    <= new_data_d;
      framing_err_q <= framing_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tick_d        = tick_q + 1'b1;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    data_out_d    = data_out_q;
    new_data_d    = 1'b0;
    framing_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (tick_q == HALF_LAST) begin
          if (!rx_s_q) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick_q == BIT_LAST) begin
          // LSB arrives first: shift right so it ends up in bit 0.
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          tick_d    = '0;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick_q == BIT_LAST) begin
          if (rx_s_q) begin
            data_out_d = shift_q;
            new_data_d = 1'b1;
            state_d    = IDLE;
          end else begin
            framing_err_d = 1'b1;
            state_d       = BRK;
          end
        end
      end
      BRK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The tick counter restarts on every state change so each state times
    // its own interval from zero.
    if (state_d != state_q) tick_d = '0;
  end

  assign dataOut    = data_out_q;
  assign newData    = new_data_q;
  assign framingErr = framing_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_receiver.sv
module tb_uart_byte_receiver;

  localparam int unsigned C    = 8;
  localparam int unsigned MAXC = 4096;
  // Frame timing from first start-bit cycle k: two sync stages plus one
  // detection cycle, half a bit to the start midpoint, nine more bit times
  // to the stop midpoint; the strobe appears in the cycle after that edge.
  localparam int unsigned EVT  = 3 + C / 2 + 9 * C;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dataOut;
  logic       newData;
  logic       framingErr;
  logic       busy;

  uart_byte_receiver #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .dataOut   (dataOut),
    .newData   (newData),
    .framingErr(framingErr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Expected behaviour per cycle.
  bit       exp_nd   [MAXC];
  bit       exp_fe   [MAXC];
  bit       exp_busy [MAXC];
  bit       dset     [MAXC];
  bit [7:0] dval     [MAXC];
  bit [7:0] cur_dout = 8'h00;
  int       nd_seen = 0;
  int       fe_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      if (dset[cyc]) cur_dout = dval[cyc];
      chk("newData", {31'd0, newData}, {31'd0, exp_nd[cyc]});
      chk("framingErr", {31'd0, framingErr}, {31'd0, exp_fe[cyc]});
      chk("busy", {31'd0, busy}, {31'd0, exp_busy[cyc]});
      chk("dataOut", {24'd0, dataOut}, {24'd0, cur_dout});
      if (newData === 1'b1) nd_seen++;
      if (framingErr === 1'b1) fe_seen++;
    end
  end

  // Minimal RAM loader: each strobe writes the next address.
  bit          ld_en = 1'b0;
  int unsigned ld_addr = 0;
  logic [7:0]  ld_mem [4];
  always @(posedge clk) begin
    if (!ld_en) ld_addr <= 0;
    else if (newData) begin
      ld_mem[ld_addr[1:0]] <= dataOut;
      ld_addr <= ld_addr + 1;
    end
  end

  task automatic hold(input logic v, input int unsigned n);
    rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends the first nbits bit periods (start, 8 data, stop) of a frame.
  // A low stop bit is followed by extra_low further low cycles.
  task automatic send(input logic [7:0] b, input logic stopv,
                      input int unsigned extra_low, input int unsigned nbits);
    int unsigned k;
    logic [9:0]  bits;
    k = cyc;
    bits = {stopv, b, 1'b0};
    for (int unsigned c = k + 3; c < k + EVT && c < MAXC; c++) exp_busy[c] = 1'b1;
    if (nbits == 10 && k + EVT < MAXC) begin
      if (stopv) begin
        exp_nd[k + EVT] = 1'b1;
        dset[k + EVT]   = 1'b1;
        dval[k + EVT]   = b;
      end else begin
        exp_fe[k + EVT] = 1'b1;
        // Stays busy until the line has been high long enough to pass the
        // synchroniser and be seen.
        for (int unsigned c = k + EVT; c < k + 10 * C + extra_low + 3 && c < MAXC; c++)
          exp_busy[c] = 1'b1;
      end
    end
    for (int unsigned i = 0; i < nbits; i++) hold(bits[i], C);
    if (nbits == 10 && !stopv) hold(1'b0, extra_low);
    rx = 1'b1;
  endtask

  task automatic do_reset();
    int unsigned n;
    n = cyc;
    for (int unsigned c = n + 1; c < n + 200 && c < MAXC; c++) begin
      exp_nd[c] = 1'b0; exp_fe[c] = 1'b0; exp_busy[c] = 1'b0; dset[c] = 1'b0;
    end
    dset[n + 1] = 1'b1;
    dval[n + 1] = 8'h00;
    reset = 1'b0;
    hold(1'b1, 1);
    chk("reset_dataOut", {24'd0, dataOut}, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'h0);
    chk("reset_newData", {31'd0, newData}, 32'h0);
    hold(1'b1, 1);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    hold(1'b1, 3);
    reset = 1'b1;
    chk("init_dataOut", {24'd0, dataOut}, 32'h0);
    chk("init_busy", {31'd0, busy}, 32'h0);
    hold(1'b1, 6);

    // 1: single frame
    send(8'h55, 1'b1, 0, 10);
    hold(1'b1, 12);
    chk("t1_dataOut", {24'd0, dataOut}, 32'h55);
    chk("t1_nd_count", nd_seen, 32'd1);
    chk("t1_fe_count", fe_seen, 32'd0);

    // 2: back-to-back frames
    send(8'hA3, 1'b1, 0, 10);
    send(8'h00, 1'b1, 0, 10);
    hold(1'b1, 12);
    chk("t2_dataOut", {24'd0, dataOut}, 32'h00);
    chk("t2_nd_count", nd_seen, 32'd3);

    // 3: short glitch rejected
    begin
      int unsigned k;
      k = cyc;
      for (int unsigned c = k + 3; c < k + 3 + C / 2; c++) exp_busy[c] = 1'b1;
      hold(1'b0, 2);
      hold(1'b1, 6);
      chk("t3_busy_low", {31'd0, busy}, 32'h0);
      hold(1'b1, 10);
      chk("t3_nd_count", nd_seen, 32'd3);
      chk("t3_fe_count", fe_seen, 32'd0);
    end

    // 4: framing error with held-low line, then recovery
    send(8'h12, 1'b1, 0, 10);
    hold(1'b1, 10);
    send(8'h7E, 1'b0, 24, 10);
    hold(1'b1, 12);
    chk("t4_dataOut_kept", {24'd0, dataOut}, 32'h12);
    chk("t4_fe_count", fe_seen, 32'd1);
    send(8'h41, 1'b1, 0, 10);
    hold(1'b1, 12);
    chk("t4_dataOut", {24'd0, dataOut}, 32'h41);
    chk("t4_nd_count", nd_seen, 32'd5);

    // 5: reset during data bit 4
    send(8'h3C, 1'b1, 0, 5);
    hold(1'b1, 3);
    do_reset();
    hold(1'b1, 16);
    chk("t5_nd_after_reset", nd_seen, 32'd5);
    send(8'h3C, 1'b1, 0, 10);
    hold(1'b1, 12);
    chk("t5_dataOut", {24'd0, dataOut}, 32'h3C);
    chk("t5_nd_count", nd_seen, 32'd6);

    // 6: loader chain
    ld_en = 1'b1;
    hold(1'b1, 2);
    send(8'h2B, 1'b1, 0, 10);
    send(8'h2E, 1'b1, 0, 10);
    send(8'h5B, 1'b1, 0, 10);
    hold(1'b1, 16);
    chk("t6_addr", ld_addr, 32'd3);
    chk("t6_mem0", {24'd0, ld_mem[0]}, 32'h2B);
    chk("t6_mem1", {24'd0, ld_mem[1]}, 32'h2E);
    chk("t6_mem2", {24'd0, ld_mem[2]}, 32'h5B);
    chk("t6_fe_count", fe_seen, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
